// File: rtl/acc_host_ctrl.sv
// Host-side controller for a matrix accelerator: loads A/B operand buffers,
// runs one multiply with a timeout guard, then streams the result out word by word.
module acc_host_ctrl #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int N_WORDS        = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic                wr_sel,
  input  logic [7:0]          wr_idx,
  input  logic [31:0]         wr_data,
  input  logic                go,
  output logic                busy,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [31:0]         rd_data,
  output logic                rd_last,
  output logic                err_timeout,
  output logic                acc_start,
  input  logic                acc_done,
  output logic [1023:0][7:0]  acc_in_A,
  output logic [1023:0][7:0]  acc_in_B,
  input  logic [1023:0][7:0]  acc_out
);

  localparam logic [1:0]    IDLE   = 2'd0;
  localparam logic [1:0]    RUN    = 2'd1;
  localparam logic [1:0]    DRAIN  = 2'd2;
  localparam int            IW     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IW-1:0] LAST   = IW'(N_WORDS - 1);
  localparam logic [31:0]   TO_LIM = 32'(TIMEOUT_CYCLES);

  logic [1:0]         state;
  logic [255:0][31:0] a_buf, b_buf, res_buf;
  logic [31:0]        cnt;
  logic [IW-1:0]      k;
  logic               xfer;

  assign wr_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign acc_start = (state == RUN);
  assign rd_valid  = (state == DRAIN);
  assign xfer      = rd_valid && rd_ready;
  assign rd_data   = res_buf[k];
  assign rd_last   = rd_valid && (k == LAST);

  // Word i occupies bytes 4i..4i+3, so the word-packed buffers map straight onto the byte ports.
  assign acc_in_A  = a_buf;
  assign acc_in_B  = b_buf;

  // Writes are only accepted in IDLE; a write on the go edge still lands before RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_buf <= '0;
      b_buf <= '0;
    end else if (wr_valid && wr_ready) begin
      if (wr_sel) b_buf[wr_idx] <= wr_data;
      else        a_buf[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      k           <= '0;
      err_timeout <= 1'b0;
      res_buf     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state       <= RUN;
            cnt         <= '0;
            err_timeout <= 1'b0;
          end
        end
        RUN: begin
          // Done is checked first so a completion on the timeout edge is not lost.
          if (acc_done) begin
            res_buf <= acc_out;
            k       <= '0;
            state   <= DRAIN;
          end else if (cnt + 32'd1 >= TO_LIM) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (k == LAST) state <= IDLE;
            else           k     <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/acc_host_ctrl.md
ACC_HOST_CTRL -- requirements
Module: acc_host_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65535: max cycles in RUN waiting for acc_done before abort.
REQ-002 Parameter N_WORDS, default 256: 32-bit words per matrix (1024 bytes).
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 wr_valid  input  1  operand write request.
REQ-006 wr_ready  output  1  operand write accepted when high with wr_valid.
REQ-007 wr_sel  input  1  target matrix, 0=A, 1=B.
REQ-008 wr_idx  input  8  word index 0..255.
REQ-009 wr_data  input  32  operand word; bits [8j+7:8j] go to byte 4*wr_idx+j.
REQ-010 go  input  1  single-cycle command to start a multiply.
REQ-011 busy  output  1  high in RUN or DRAIN.
REQ-012 rd_valid  output  1  result word available.
REQ-013 rd_ready  input  1  consumer accepts result word.
REQ-014 rd_data  output  32  result word, same byte packing as wr_data.
REQ-015 rd_last  output  1  high with rd_valid on word N_WORDS-1.
REQ-016 err_timeout  output  1  sticky flag, last run aborted on timeout.
REQ-017 acc_start  output  1  start to matrix accelerator.
REQ-018 acc_done  input  1  completion from matrix accelerator.
REQ-019 acc_in_A, acc_in_B  output  [1023:0][7:0]  operand buffers, driven straight from registers.
REQ-020 acc_out  input  [1023:0][7:0]  accelerator result.

Function
REQ-021 States SHALL be IDLE, RUN, DRAIN; wr_ready = (state==IDLE); busy = (state!=IDLE).
REQ-022 In IDLE a wr_valid&wr_ready edge SHALL write 4 bytes of the selected buffer; other bytes unchanged.
REQ-023 go sampled high in IDLE SHALL move to RUN next cycle; go in RUN or DRAIN ignored.
REQ-024 go and an accepted write on the same edge: write SHALL commit on that edge and be part of the run.
REQ-025 acc_start SHALL be high every cycle in RUN, low otherwise (first high cycle = edge after go).
REQ-026 acc_done sampled high in RUN SHALL capture acc_out into a result buffer and move to DRAIN; acc_done outside RUN ignored.
REQ-027 go on a run SHALL clear err_timeout and the 16-bit+ cycle counter on entering RUN.
REQ-028 Counter increments each RUN cycle without acc_done; reaching TIMEOUT_CYCLES SHALL set err_timeout, return to IDLE, no DRAIN, result buffer unchanged.
REQ-029 acc_done on the same edge the counter reaches TIMEOUT_CYCLES: done wins, no error.
REQ-030 In DRAIN rd_valid SHALL be high, rd_data = result word k (k from 0), advancing k only on rd_valid&rd_ready.
REQ-031 rd_data and rd_last SHALL hold stable while rd_valid&!rd_ready.
REQ-032 Transfer of word N_WORDS-1 SHALL return to IDLE next cycle; rd_valid low in IDLE and RUN.
REQ-033 Operand buffers SHALL retain contents across runs; only writes or reset change them.

Reset
REQ-034 rst_n low at an edge SHALL force IDLE, clear A, B and result buffers to 0, counter to 0, err_timeout, acc_start, rd_valid, rd_last, busy to 0; wr_ready 1.
REQ-035 Reset mid-RUN or mid-DRAIN SHALL abort immediately, no rd transfer or acc_start after that edge.

Verification
REQ-036 Write A word0=0x04030201, B word0=0x08070605, go; acc_done after 10 cycles with acc_out byte0..3=0x11,0x22,0x33,0x44 -> acc_start high exactly 10 cycles, rd_data word0=0x44332211.
REQ-037 Drain with rd_ready toggled every other cycle -> exactly 256 transfers, rd_last only on 256th, data stable under stall, then IDLE and wr_ready=1.
REQ-038 TIMEOUT_CYCLES=20, acc_done never asserted -> err_timeout=1 after 20 RUN cycles, state IDLE, rd_valid never high; next go clears err_timeout.
REQ-039 wr_valid held during RUN -> wr_ready=0, buffer unchanged until back in IDLE, then write lands.
REQ-040 Same-edge go and write of A word5=0xDEADBEEF -> acc_in_A bytes 20..23 = EF,BE,AD,DE in first acc_start cycle.
REQ-041 rst_n low for 1 cycle during DRAIN word 100 -> busy, rd_valid, acc_start 0 next cycle, acc_in_A and acc_in_B all zero.
